// File: rtl/receiver_pkg.sv
// Shared serial frame constants for the transceiver: frame size and line levels.
// Imported by both the sender and the receiver so the two sides cannot disagree.
package receiver_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage : receiver_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; the reset value is chosen by the
// instantiating block so the output starts at the input's natural idle level.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments let meta and q shift together on one edge;
  // blocking ones here would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/receiver.sv
// Oversampling serial receiver: 1 start, 8 data (LSB first), 1 stop bit.
// Presents each good byte with a one-cycle rx_status pulse; bad stop bits pulse rx_err.
module receiver
  import receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       rx_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]     FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   status_d, err_d;
  logic                   din_s;
  logic                   half_hit, full_hit;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (IDLE_LVL)
  ) u_sync_din (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (din_s)
  );

  assign half_hit = (cnt_q == HALF_LAST);
  assign full_hit = (cnt_q == FULL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_status <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data   <= data_d;
      rx_status <= status_d;
      rx_err    <= err_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = rx_data;
    status_d = 1'b0;
    err_d    = 1'b0;

    if (!rx_en) begin
      // Receiver disabled: drop any partial frame without reporting it.
      state_d = S_IDLE;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          bit_d = '0;
          if (din_s == START_LVL) state_d = S_START;
        end

        S_START: begin
          if (half_hit) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = (din_s == START_LVL) ? S_DATA : S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (full_hit) begin
            cnt_d   = '0;
            shift_d = {din_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) state_d = S_STOP;
            else                   bit_d   = bit_q + BIT_CNT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (full_hit) begin
            cnt_d = '0;
            if (din_s == STOP_LVL) begin
              data_d   = shift_q;
              status_d = 1'b1;
              state_d  = S_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = S_WAIT_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_WAIT_IDLE: begin
          // A break or stuck-low line must go high before another start is accepted.
          cnt_d = '0;
          if (din_s == IDLE_LVL) state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

endmodule : receiver

// File: tb/tb_receiver.sv
// Bench for the serial receiver: a vector table, hand-written corner sequences and
// random frames checked against a frame-level event model.
module tb_receiver;

  localparam int CPB = 16;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         drop_bit;
    int         exp_status;
    int         exp_err;
    logic [7:0] exp_rx_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rx_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int both_cnt = 0;
  int dis_cnt = 0;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [7:0] model_rx = 8'h00;

  receiver #(
    .CLKS_PER_BIT (CPB),
    .CNT_W        (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .rx_en     (rx_en),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .rx_err    (rx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_status && rx_err) both_cnt <= both_cnt + 1;
      if ((rx_status || rx_err) && !rx_en) dis_cnt <= dis_cnt + 1;
      if (rx_status) obs_q.push_back('{err: 1'b0, data: rx_data, cyc: cyc});
      if (rx_err)    obs_q.push_back('{err: 1'b1, data: 8'h00, cyc: cyc});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: a frame seen whole with rx_en high yields one event.
  task automatic model_frame(input logic [7:0] data, input bit stop, input bit dropped);
    if (!dropped) begin
      if (stop) begin
        exp_q.push_back('{err: 1'b0, data: data, cyc: 0});
        model_rx = data;
      end else begin
        exp_q.push_back('{err: 1'b1, data: 8'h00, cyc: 0});
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop, input int drop_bit,
                            output int start_cyc);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i == drop_bit) rx_en = 1'b0;
      din = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    din = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_event_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_ev%0d_kind", tag, i), obs_q[i].err, exp_q[i].err);
      check($sformatf("%s_ev%0d_data", tag, i), obs_q[i].data, exp_q[i].data);
    end
    check({tag, "_rx_data"}, rx_data, model_rx);
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic int count_kind(input bit err);
    int c = 0;
    foreach (obs_q[i]) if (obs_q[i].err == err) c++;
    return c;
  endfunction

  initial begin
    vec_t vecs[6];
    int   t0, t1;
    logic [7:0] d;
    bit   stop;
    bit   prev_bad;
    int   gap;

    vecs[0] = '{8'hA5, 1'b1, -1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, -1, 0, 1, 8'hA5};
    vecs[2] = '{8'h5A, 1'b1,  5, 0, 0, 8'hA5};
    vecs[3] = '{8'h81, 1'b1, -1, 1, 0, 8'h81};
    vecs[4] = '{8'h00, 1'b1, -1, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, 1'b1, -1, 1, 0, 8'hFF};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_status", rx_status, 1'b0);
    check("reset_rx_err", rx_err, 1'b0);
    rst_n = 1'b1;
    idle(2 * CPB);

    // First frame: event count and latency from the falling edge
    send_frame(8'hA5, 1'b1, -1, t0);
    idle(2 * CPB);
    check("a5_status_count", count_kind(1'b0), 1);
    check("a5_err_count", count_kind(1'b1), 0);
    check("a5_rx_data", rx_data, 8'hA5);
    if (obs_q.size() > 0)
      check("a5_latency_window",
            ((obs_q[0].cyc - t0) >= 2 + CPB / 2 + 9 * CPB) &&
            ((obs_q[0].cyc - t0) <= 2 + CPB / 2 + 9 * CPB + 2), 1'b1);
    obs_q.delete();

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].drop_bit, t0);
      idle(2 * CPB);
      check($sformatf("vec%0d_status_count", v), count_kind(1'b0), vecs[v].exp_status);
      check($sformatf("vec%0d_err_count", v), count_kind(1'b1), vecs[v].exp_err);
      check($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].exp_rx_data);
      obs_q.delete();
      rx_en = 1'b1;
      idle(CPB);
    end
    model_rx = 8'hFF;

    // Back-to-back 0x00 then 0xFF with no idle gap
    send_frame(8'h00, 1'b1, -1, t0);
    send_frame(8'hFF, 1'b1, -1, t1);
    idle(2 * CPB);
    check("b2b_status_count", count_kind(1'b0), 2);
    if (obs_q.size() == 2) begin
      check("b2b_first_data", obs_q[0].data, 8'h00);
      check("b2b_second_data", obs_q[1].data, 8'hFF);
      check("b2b_spacing", obs_q[1].cyc - obs_q[0].cyc, 160);
    end
    obs_q.delete();

    // Short glitch is rejected, then the line still works
    din = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    check("glitch_no_events", obs_q.size(), 0);
    check("glitch_rx_data_kept", rx_data, 8'hFF);
    send_frame(8'h96, 1'b1, -1, t0);
    model_frame(8'h96, 1'b1, 1'b0);
    idle(2 * CPB);
    compare_events("after_glitch");

    // Bad stop bit, then line held low: one error only, then recovery
    send_frame(8'h3C, 1'b0, -1, t0);
    model_frame(8'h3C, 1'b0, 1'b0);
    din = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    compare_events("break");
    idle(2 * CPB);
    send_frame(8'h3C, 1'b1, -1, t0);
    model_frame(8'h3C, 1'b1, 1'b0);
    idle(2 * CPB);
    compare_events("after_break");

    // Reset in the middle of the data bits
    din = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      din = i[0];
      repeat (CPB) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_rx_status", rx_status, 1'b0);
    check("midreset_rx_err", rx_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_rx = 8'h00;
    idle(2 * CPB);
    send_frame(8'h7E, 1'b1, -1, t0);
    model_frame(8'h7E, 1'b1, 1'b0);
    idle(2 * CPB);
    compare_events("after_reset");

    // Random frames, random gaps, occasional bad stop bits
    prev_bad = 1'b0;
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = prev_bad ? CPB + $urandom_range(0, 8) : $urandom_range(0, 20);
      idle(gap);
      send_frame(d, stop, -1, t0);
      model_frame(d, stop, 1'b0);
      prev_bad = !stop;
    end
    idle(3 * CPB);
    compare_events("random");

    check("no_simultaneous_pulses", both_cnt, 0);
    check("no_pulses_while_disabled", dis_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_receiver
